// File: rtl/sys_acc_pkg.sv
// Shared widths, types and lane helpers for the systolic accumulate/writeback path.
// The lane widths live here so every stage and the lane adder agree on them.
package sys_acc_pkg;

  localparam int ARRAY_M      = 4;
  localparam int PE_OUT_WIDTH = 32;
  localparam int BIAS_WIDTH   = 32;
  localparam int ACC_WIDTH    = 48;

  typedef logic signed [ACC_WIDTH-1:0]    acc_t;
  typedef logic signed [PE_OUT_WIDTH-1:0] pe_t;
  typedef logic signed [BIAS_WIDTH-1:0]   bias_t;

  // Where a row's accumulation base comes from.
  typedef enum logic [1:0] {
    BASE_BIAS,
    BASE_S2,
    BASE_W,
    BASE_OBUF
  } base_sel_e;

  function automatic acc_t acc_lane(input logic [ARRAY_M*ACC_WIDTH-1:0] word, input int m);
    return word[m*ACC_WIDTH +: ACC_WIDTH];
  endfunction

  function automatic pe_t pe_lane(input logic [ARRAY_M*PE_OUT_WIDTH-1:0] word, input int m);
    return word[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
  endfunction

  function automatic bias_t bias_lane(input logic [ARRAY_M*BIAS_WIDTH-1:0] word, input int m);
    return word[m*BIAS_WIDTH +: BIAS_WIDTH];
  endfunction

  function automatic acc_t sext_pe(input pe_t v);
    return ACC_WIDTH'(v);
  endfunction

  function automatic acc_t sext_bias(input bias_t v);
    return ACC_WIDTH'(v);
  endfunction

endpackage

// File: rtl/systolic_acc_writeback_acc_lane_add.sv
// One accumulator lane: pick the base (bias, forwarded word or obuf) and add the PE result.
// Lanes are independent; the sum wraps modulo 2^ACC_WIDTH.
module acc_lane_add
  import sys_acc_pkg::*;
(
  input  base_sel_e base_sel,
  input  bias_t     bias,
  input  acc_t      s2_data,
  input  acc_t      w_data,
  input  acc_t      obuf_data,
  input  pe_t       pe,
  output acc_t      sum
);

  acc_t base;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    base = obuf_data;
    unique case (base_sel)
      BASE_BIAS: base = sext_bias(bias);
      BASE_S2:   base = s2_data;
      BASE_W:    base = w_data;
      BASE_OBUF: base = obuf_data;
      default:   base = obuf_data;
    endcase
  end

  assign sum = base + sext_pe(pe);

endmodule

// File: rtl/systolic_acc_writeback.sv
// Read-modify-write accumulation of systolic rows into the output buffer (write at t+2).
// Hazards on the word in S2 or the word just written are forwarded so back-to-back rows never stall.
module systolic_acc_writeback
  import sys_acc_pkg::*;
#(
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] sys_out,
  input  logic                            sys_out_valid,
  input  logic [OBUF_ADDR_WIDTH-1:0]      sys_out_addr,
  input  logic                            sys_out_first,
  input  logic [BBUF_ADDR_WIDTH-1:0]      bias_addr,
  output logic                            bbuf_read_req,
  output logic [BBUF_ADDR_WIDTH-1:0]      bbuf_read_addr,
  input  logic [ARRAY_M*BIAS_WIDTH-1:0]   bbuf_read_data,
  output logic                            obuf_read_req,
  output logic [OBUF_ADDR_WIDTH-1:0]      obuf_read_addr,
  input  logic [ARRAY_M*ACC_WIDTH-1:0]    obuf_read_data,
  output logic                            obuf_write_req,
  output logic [OBUF_ADDR_WIDTH-1:0]      obuf_write_addr,
  output logic [ARRAY_M*ACC_WIDTH-1:0]    obuf_write_data,
  output logic                            busy,
  output logic [31:0]                     rows_written
);

  logic                            s1_valid;
  logic                            s1_first;
  logic [OBUF_ADDR_WIDTH-1:0]      s1_addr;
  logic [ARRAY_M*PE_OUT_WIDTH-1:0] s1_row;

  logic                            s2_valid;
  logic [OBUF_ADDR_WIDTH-1:0]      s2_addr;
  logic [ARRAY_M*ACC_WIDTH-1:0]    s2_data;

  logic                            w_valid;
  logic [OBUF_ADDR_WIDTH-1:0]      w_addr;
  logic [ARRAY_M*ACC_WIDTH-1:0]    w_data;

  logic [ARRAY_M*ACC_WIDTH-1:0]    sum_word;
  base_sel_e                       base_sel;

  // S0: read strobes go straight out so the data lands alongside the row in S1.
  assign obuf_read_req  = sys_out_valid & ~sys_out_first & ~reset;
  assign bbuf_read_req  = sys_out_valid &  sys_out_first & ~reset;
  assign obuf_read_addr = reset ? '0 : sys_out_addr;
  assign bbuf_read_addr = reset ? '0 : bias_addr;

  // S1 base select: the newest in-flight copy of the word wins over obuf's stale read.
  always_comb begin
    base_sel = BASE_OBUF;
    if (s1_first)                            base_sel = BASE_BIAS;
    else if (s2_valid && s2_addr == s1_addr) base_sel = BASE_S2;
    else if (w_valid && w_addr == s1_addr)   base_sel = BASE_W;
  end

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    acc_lane_add u_acc_lane_add (
      .base_sel  (base_sel),
      .bias      (bias_lane(bbuf_read_data, m)),
      .s2_data   (acc_lane(s2_data, m)),
      .w_data    (acc_lane(w_data, m)),
      .obuf_data (acc_lane(obuf_read_data, m)),
      .pe        (pe_lane(s1_row, m)),
      .sum       (sum_word[m*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are cleared as well as valids so the write port reads zero out of reset.
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_addr      <= '0;
      s1_row       <= '0;
      s2_valid     <= 1'b0;
      s2_addr      <= '0;
      s2_data      <= '0;
      w_valid      <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      rows_written <= '0;
    end else begin
      s1_valid <= sys_out_valid;
      if (sys_out_valid) begin
        s1_first <= sys_out_first;
        s1_addr  <= sys_out_addr;
        s1_row   <= sys_out;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_data <= sum_word;
      end
      w_valid <= s2_valid;
      if (s2_valid) begin
        w_addr       <= s2_addr;
        w_data       <= s2_data;
        rows_written <= rows_written + 32'd1;
      end
    end
  end

  assign obuf_write_req  = s2_valid;
  assign obuf_write_addr = s2_addr;
  assign obuf_write_data = s2_data;
  assign busy            = s1_valid | s2_valid;

endmodule
